cache_fill_ctrl: RTL

// Miss-fill sequencer for the 2-way set-associative data array (64 sets x 2 ways x 8 x 16-bit words).
// On a miss, it issues eight pipelined word reads to main memory.
// It steers each returned word into the victim way, set and word slot of the data array.
// It then pulses the tag-array write to validate the block.
// It sits between the cache hit/miss logic, main memory and the data/tag arrays.

---
 rtl/cache_fill_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cache_fill_ctrl.sv
// Miss-fill sequencer: streams one block from main memory into the victim way of the
// set-associative data array, then validates the block through the tag array.
//
// Handshake: a miss is accepted only in IDLE. In FILL one read is issued per cycle until
// NUM_WORDS requests are out. A returned word is consumed when memory_data_valid=1 and
// fewer words have been received than requested. Returns arrive in request order.
module cache_fill_ctrl #(
    parameter int NUM_WORDS = 8,
    parameter int NUM_SETS  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [15:0]           miss_address,
    input  logic                  miss_way,
    input  logic                  memory_data_valid,
    input  logic [15:0]           memory_data_in,
    output logic                  fsm_busy,
    output logic                  mem_read,
    output logic [15:0]           memory_address,
    output logic                  data_we0,
    output logic                  data_we1,
    output logic [NUM_SETS-1:0]   block_enable,
    output logic [NUM_WORDS-1:0]  word_enable,
    output logic [15:0]           data_out,
    output logic                  write_tag_array,
    output logic                  fill_done,
    output logic                  state_dbg
);

    localparam int WW = $clog2(NUM_WORDS);
    localparam int CW = WW + 1;
    localparam int SW = $clog2(NUM_SETS);
    localparam int OB = WW + 1;  // byte-offset bits inside a block

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   issue_cnt, issue_d;
    logic [CW-1:0]   recv_cnt, recv_d;
    logic [15:0]     base_q;
    logic [SW-1:0]   set_q;
    logic            way_q;
    logic            accept;
    logic            consume;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^miss_address[OB-1:0];
    assign accept    = (state == IDLE) && miss_detected;
    assign consume   = (state == FILL) && memory_data_valid && (recv_cnt < issue_cnt);
    assign state_dbg = logic'(state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base_q    <= '0;
            set_q     <= '0;
            way_q     <= 1'b0;
        end else begin
            state     <= state_d;
            issue_cnt <= issue_d;
            recv_cnt  <= recv_d;
            if (accept) begin
                base_q <= {miss_address[15:OB], {OB{1'b0}}};
                set_q  <= miss_address[OB +: SW];
                way_q  <= miss_way;
            end
        end
    end

    always_comb begin
        state_d         = state;
        issue_d         = issue_cnt;
        recv_d          = recv_cnt;
        fsm_busy        = 1'b0;
        mem_read        = 1'b0;
        memory_address  = '0;
        data_we0        = 1'b0;
        data_we1        = 1'b0;
        block_enable    = '0;
        word_enable     = '0;
        data_out        = '0;
        write_tag_array = 1'b0;
        fill_done       = 1'b0;

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_cnt < CW'(NUM_WORDS)) begin
                    mem_read       = 1'b1;
                    memory_address = base_q + 16'({issue_cnt, 1'b0});
                    issue_d        = issue_cnt + 1'b1;
                end
                if (consume) begin
                    data_we0     = ~way_q;
                    data_we1     = way_q;
                    block_enable = NUM_SETS'(1) << set_q;
                    word_enable  = NUM_WORDS'(1) << recv_cnt[WW-1:0];
                    data_out     = memory_data_in;
                    recv_d       = recv_cnt + 1'b1;
                    // Last word: validate the block and return to IDLE with clean counters.
                    if (recv_cnt == CW'(NUM_WORDS - 1)) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        state_d         = IDLE;
                        issue_d         = '0;
                        recv_d          = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
